// File: rtl/acondicionador_pulsadores.sv
// Push-button conditioner for the BASYS2 board.
// Each raw button goes through a two-flop synchronizer and then through its
// own debounce FSM. The FSM produces a clean level plus one-cycle press and
// release strobes, all registered on clk.
module acondicionador_pulsadores #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic             clk,
  input  logic             botonreset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CHK_PRESS = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_CHK_REL   = 2'd3
  } state_t;

  // Last count value before a candidate level is accepted. The counter runs
  // 0..D-1 while in a CHK state, so the input is seen stable D consecutive
  // times after the state is entered.
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  logic [N_BTN-1:0] r_s1;
  logic [N_BTN-1:0] r_s2;

  // Two-flop synchronizer for the asynchronous button inputs
  always_ff @(posedge clk or posedge botonreset) begin
    if (botonreset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= btn_raw;
      r_s2 <= r_s1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_BTN; g++) begin : g_btn
      state_t           r_state;
      state_t           w_state_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic             r_level;
      logic             w_level_nxt;
      logic             r_press;
      logic             w_press_nxt;
      logic             r_release;
      logic             w_release_nxt;
      logic             w_in;
      logic             w_cnt_done;

      assign w_in       = r_s2[g];
      assign w_cnt_done = (r_cnt == LP_CNT_LAST);

      // State, counter and registered outputs; reset aborts everything to IDLE
      always_ff @(posedge clk or posedge botonreset) begin
        if (botonreset) begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_level   <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_state   <= w_state_nxt;
          r_cnt     <= w_cnt_nxt;
          r_level   <= w_level_nxt;
          r_press   <= w_press_nxt;
          r_release <= w_release_nxt;
        end
      end

      // Debounce next-state logic: a level change is accepted only after the
      // synchronized input holds the new value for D samples in a CHK state
      always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
          ST_IDLE: begin
            w_level_nxt = 1'b0;
            if (w_in) begin
              w_state_nxt = ST_CHK_PRESS;
              w_cnt_nxt   = '0;
            end
          end
          ST_CHK_PRESS: begin
            w_level_nxt = 1'b0;
            if (!w_in) begin
              w_state_nxt = ST_IDLE;
            end else if (w_cnt_done) begin
              w_state_nxt = ST_PRESSED;
              w_level_nxt = 1'b1;
              w_press_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + LP_CNT_ONE;
            end
          end
          ST_PRESSED: begin
            w_level_nxt = 1'b1;
            if (!w_in) begin
              w_state_nxt = ST_CHK_REL;
              w_cnt_nxt   = '0;
            end
          end
          ST_CHK_REL: begin
            w_level_nxt = 1'b1;
            if (w_in) begin
              w_state_nxt = ST_PRESSED;
            end else if (w_cnt_done) begin
              w_state_nxt   = ST_IDLE;
              w_level_nxt   = 1'b0;
              w_release_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + LP_CNT_ONE;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b0;
          end
        endcase
      end

      assign btn_level[g]   = r_level;
      assign btn_press[g]   = r_press;
      assign btn_release[g] = r_release;
    end
  endgenerate

endmodule

// File: tb/tb_acondicionador_pulsadores.sv
// Bench for acondicionador_pulsadores with N_BTN=3, DEBOUNCE_CYCLES=4, CNT_W=3.
// A per-cycle vector table drives btn_raw; expected outputs go through a
// scoreboard queue and are compared one cycle later, just after the edge.
module tb_acondicionador_pulsadores;

  localparam int N_BTN = 3;
  localparam int D     = 4;
  localparam int CW    = 3;
  localparam int N_VEC = 46;

  logic             clk;
  logic             botonreset;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  acondicionador_pulsadores #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .botonreset (botonreset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] raw;
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
  } vec_t;

  typedef struct packed {
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
  } exp_t;

  vec_t tbl [0:N_VEC-1];
  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input string field,
                     input logic [2:0] act, input logic [2:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s %s: got %b expected %b", tag, field, act, req);
    end
  endtask

  task automatic chk_now(input string tag, input exp_t e);
    chk(tag, "btn_level", btn_level, e.lvl);
    chk(tag, "btn_press", btn_press, e.prs);
    chk(tag, "btn_release", btn_release, e.rel);
  endtask

  // Drive one raw sample, queue its expectation, compare after the edge
  task automatic step(input logic [2:0] raw, input logic [2:0] lvl,
                      input logic [2:0] prs, input logic [2:0] rel,
                      input string tag);
    exp_t e;
    btn_raw = raw;
    e.lvl = lvl;
    e.prs = prs;
    e.rel = rel;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk_now(tag, e);
  endtask

  // Set one bit of a table field (0 raw, 1 level, 2 press, 3 release) over a range
  task automatic mark(input int f, input int b, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      case (f)
        0:       tbl[i].raw[b] = 1'b1;
        1:       tbl[i].lvl[b] = 1'b1;
        2:       tbl[i].prs[b] = 1'b1;
        default: tbl[i].rel[b] = 1'b1;
      endcase
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    z = '0;
    for (int i = 0; i < N_VEC; i++) tbl[i] = '0;

    // Index = post-reset edge number (0 = first sampling edge).
    // All held from edge 0: press at 6. Buttons 0/1 drop at 8: release at 14.
    // Button 0: 3-sample glitch at 16..18, no effect; pressed again at 36: press at 42.
    // Button 1: bounce 1,0,1 at 16..18, held to 27: press at 24, release at 34.
    // Button 2: held, dips at 20..21 (ignored), drops at 26: release at 32,
    //           pressed again at 36 together with button 0: press at 42.
    mark(0, 0, 0, 7);   mark(0, 0, 16, 18); mark(0, 0, 36, 45);
    mark(0, 1, 0, 7);   mark(0, 1, 16, 16); mark(0, 1, 18, 27);
    mark(0, 2, 0, 19);  mark(0, 2, 22, 25); mark(0, 2, 36, 45);
    mark(1, 0, 6, 13);  mark(1, 0, 42, 45);
    mark(1, 1, 6, 13);  mark(1, 1, 24, 33);
    mark(1, 2, 6, 31);  mark(1, 2, 42, 45);
    mark(2, 0, 6, 6);   mark(2, 0, 42, 42);
    mark(2, 1, 6, 6);   mark(2, 1, 24, 24);
    mark(2, 2, 6, 6);   mark(2, 2, 42, 42);
    mark(3, 0, 14, 14);
    mark(3, 1, 14, 14); mark(3, 1, 34, 34);
    mark(3, 2, 32, 32);

    // Reset held with all buttons pressed: outputs must stay low
    botonreset = 1'b1;
    btn_raw    = 3'b111;
    #1;
    chk_now("reset_async", z);
    for (int i = 0; i < 3; i++) step(3'b111, 3'b000, 3'b000, 3'b000, $sformatf("in_reset%0d", i));
    botonreset = 1'b0;

    for (int i = 0; i < N_VEC; i++)
      step(tbl[i].raw, tbl[i].lvl, tbl[i].prs, tbl[i].rel, $sformatf("vec%0d", i));

    // Buttons 0 and 2 released; reset lands while both are in CHK_REL
    for (int i = 46; i < 50; i++) step(3'b000, 3'b101, 3'b000, 3'b000, $sformatf("rel_chk%0d", i));
    botonreset = 1'b1;
    #1;
    chk_now("reset_in_chk_rel", z);
    for (int i = 0; i < 2; i++) step(3'b000, 3'b000, 3'b000, 3'b000, $sformatf("rst_hold%0d", i));
    botonreset = 1'b0;
    for (int i = 0; i < 10; i++) step(3'b000, 3'b000, 3'b000, 3'b000, $sformatf("post_rst%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
